imem_loader_arb: RTL and testbench

Instruction-memory owner and loader for the single-cycle CPU. It arbitrates the single-port instruction RAM between the fetch unit (RUN mode, read-only) and a byte-stream program loader (LOAD mode, write). The loader takes bytes from the UART receiver, assembles 32-bit big-endian words, writes them from word address 0 upward, and holds the CPU in reset until the image is complete.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/byte_packer.sv | 39 +++
 rtl/imem_loader_arb.sv | 192 +++++++++++++++++++
 tb/tb_imem_loader_arb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader/arbiter.
// Optional build macro: IMEM_LOADER_CKSUM_EN adds the CKSUM state.
package imem_loader_pkg;

    localparam int unsigned DEFAULT_ADDR_W      = 14;
    localparam int unsigned DEFAULT_TIMEOUT_CYC = 1000000;
    localparam int unsigned WORD_BYTES          = 4;

    typedef enum logic [2:0] {
        StRun,
        StHdr0,
        StHdr1,
        StData,
        StWrite,
        StFlush,
`ifdef IMEM_LOADER_CKSUM_EN
        StErr,
        StCksum
`else
        StErr
`endif
    } state_e;

endpackage

// File: rtl/byte_packer.sv
// Collects WORD_BYTES bytes MSB first into one word; pulses word_valid_o
// in the cycle the final byte of a word is taken.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_i,
    output logic [WORD_BYTES*8-1:0] word_o,
    output logic                    word_valid_o
);

    localparam int unsigned     CntW    = $clog2(WORD_BYTES);
    localparam logic [CntW-1:0] LastCnt = CntW'(WORD_BYTES - 1);

    logic [CntW-1:0]         cnt_q;
    logic [WORD_BYTES*8-1:0] word_q;
    logic                    last_byte;

    assign last_byte    = (cnt_q == LastCnt);
    assign word_valid_o = byte_valid_i & ~clear_i & last_byte;
    assign word_o       = word_q;

    // Shift in accepted bytes; the byte counter is held at zero while cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (byte_valid_i) begin
            word_q <= {word_q[WORD_BYTES*8-9:0], byte_i};
            cnt_q  <= last_byte ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader_arb.sv
// Instruction RAM owner: fetch reads it in RUN, a byte-stream loader writes
// it (big-endian words from address 0) and holds the CPU in reset meanwhile.
// Optional build macro: IMEM_LOADER_CKSUM_EN requires a trailing checksum
// byte so that the 8-bit sum of all data bytes plus it is zero.
module imem_loader_arb
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              prog_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [31:0]       cpu_instr,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned     TmoW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TmoW-1:0] TmoMax   = TmoW'(TIMEOUT_CYC - 1);
    localparam logic [31:0]     MaxWords = 32'(1) << ADDR_W;

    state_e          state_q;
    logic [ADDR_W:0] index_q;    // one extra bit so N = 2^ADDR_W ends without wrap
    logic [15:0]     count_q;
    logic [TmoW-1:0] tmo_q;
    logic            prog_q;

    logic            waiting;
    logic            accept;
    logic            prog_rise;
    logic            tmo_hit;
    logic [15:0]     hdr_n;
    logic [ADDR_W:0] index_inc;
    logic            last_word;
    logic            word_valid;
    logic [31:0]     packed_word;

`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]      sum_q;
    logic [7:0]      cksum_total;
    assign cksum_total = sum_q + rx_data;
`endif

    // States that are waiting on the byte stream (and can time out).
    always_comb begin
        waiting = 1'b0;
        unique case (state_q)
            StHdr0, StHdr1, StData: waiting = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
            StCksum:                waiting = 1'b1;
`endif
            default:                waiting = 1'b0;
        endcase
    end

    assign rx_ready  = waiting & ~reset;
    assign accept    = rx_valid & rx_ready;
    assign prog_rise = prog_req & ~prog_q;
    assign tmo_hit   = waiting & ~accept & (tmo_q == TmoMax);
    assign hdr_n     = {count_q[15:8], rx_data};
    assign index_inc = index_q + 1'b1;
    assign last_word = (32'(index_inc) == 32'(count_q));

    byte_packer u_byte_packer (
        .clk_i        (clock),
        .rst_i        (reset),
        .clear_i      (state_q != StData),
        .byte_valid_i (accept && (state_q == StData)),
        .byte_i       (rx_data),
        .word_o       (packed_word),
        .word_valid_o (word_valid)
    );

    // Loader FSM with its word index, header count, idle timer and checksum.
    always_ff @(posedge clock) begin
        // Track prog_req even in reset so a level held across reset is no edge.
        prog_q <= prog_req;
        if (reset) begin
            state_q <= StRun;
            index_q <= '0;
            count_q <= '0;
            tmo_q   <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            // Non-waiting states hold the timer at zero, which covers state entry.
            if (!waiting || accept) begin
                tmo_q <= '0;
            end else if (tmo_q != TmoMax) begin
                tmo_q <= tmo_q + 1'b1;
            end

            unique case (state_q)
                StRun, StErr: begin
                    if (prog_rise) begin
                        state_q <= StHdr0;
`ifdef IMEM_LOADER_CKSUM_EN
                        sum_q   <= '0;
`endif
                    end
                end
                StHdr0: begin
                    if (tmo_hit) begin
                        state_q <= StErr;
                    end else if (accept) begin
                        count_q[15:8] <= rx_data;
                        state_q       <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (tmo_hit) begin
                        state_q <= StErr;
                    end else if (accept) begin
                        count_q <= hdr_n;
                        if (hdr_n == 16'd0) begin
                            state_q <= StFlush;
                        end else if (32'(hdr_n) > MaxWords) begin
                            state_q <= StErr;
                        end else begin
                            index_q <= '0;
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (tmo_hit) begin
                        state_q <= StErr;
                    end else if (word_valid) begin
                        state_q <= StWrite;
                    end
`ifdef IMEM_LOADER_CKSUM_EN
                    if (accept) begin
                        sum_q <= sum_q + rx_data;
                    end
`endif
                end
                StWrite: begin
                    index_q <= index_inc;
                    if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
                        state_q <= StCksum;
`else
                        state_q <= StFlush;
`endif
                    end else begin
                        state_q <= StData;
                    end
                end
                StFlush: begin
                    state_q <= StRun;
                end
`ifdef IMEM_LOADER_CKSUM_EN
                StCksum: begin
                    if (tmo_hit) begin
                        state_q <= StErr;
                    end else if (accept) begin
                        state_q <= (cksum_total == 8'd0) ? StFlush : StErr;
                    end
                end
`endif
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    // RUN read path is a pure mux; write strobe and done are masked in reset.
    always_comb begin
        busy      = (state_q != StRun);
        cpu_rst   = reset | busy;
        mem_addr  = busy ? index_q[ADDR_W-1:0] : cpu_addr;
        cpu_instr = busy ? 32'h0000_0000 : mem_rdata;
        mem_wdata = packed_word;
        mem_we    = (state_q == StWrite) & ~reset;
        done      = (state_q == StFlush) & ~reset;
        err       = (state_q == StErr);
    end

endmodule

// File: tb/tb_imem_loader_arb.sv
// Directed bench for imem_loader_arb: a per-cycle vector table plus a
// hand-written idle-timeout sequence. Build with IMEM_LOADER_CKSUM_EN to
// include the checksum vectors.
module tb_imem_loader_arb;

    localparam int unsigned AW  = 14;
    localparam int unsigned TMO = 20;

    localparam logic [2:0] PRun   = 3'd0;  // RUN: fetch owns the RAM
    localparam logic [2:0] PLoad  = 3'd1;  // HDR0/HDR1/DATA/CKSUM: byte accepted
    localparam logic [2:0] PWrite = 3'd2;
    localparam logic [2:0] PFlush = 3'd3;
    localparam logic [2:0] PErr   = 3'd4;

    localparam logic [AW-1:0] FetchAddr = 14'h3;
    localparam logic [31:0]   FetchData = 32'h2008_0005;

    typedef struct packed {
        logic          rst;
        logic          prog;
        logic          vld;
        logic [7:0]    data;
        logic [2:0]    ph;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          prog_req;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_instr;
    logic          cpu_rst;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    logic          busy;
    logic          done;
    logic          err;

    int   total  = 0;
    int   passed = 0;
    vec_t vecs[$];

    always #5 clock = ~clock;

    imem_loader_arb #(
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .prog_req  (prog_req),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .cpu_addr  (cpu_addr),
        .cpu_instr (cpu_instr),
        .cpu_rst   (cpu_rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    function automatic vec_t mk(input logic rst, input logic prog, input logic vld,
                                input logic [7:0] data, input logic [2:0] ph,
                                input logic [AW-1:0] addr, input logic [31:0] wdata);
        vec_t v;
        v.rst = rst; v.prog = prog; v.vld = vld; v.data = data;
        v.ph = ph; v.addr = addr; v.wdata = wdata;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    endtask

    // Drive one row between edges, then compare the outputs it should produce.
    task automatic apply(input vec_t v, input int idx);
        logic e_rdy, e_we, e_crst, e_busy, e_done, e_err;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_instr;
        @(negedge clock);
        reset = v.rst; prog_req = v.prog; rx_valid = v.vld; rx_data = v.data;
        #1;
        e_rdy = 1'b0; e_we = 1'b0; e_crst = 1'b1; e_busy = 1'b1; e_done = 1'b0;
        e_err = 1'b0; e_addr = v.addr; e_instr = 32'h0;
        case (v.ph)
            PRun: begin
                e_crst = v.rst; e_busy = 1'b0; e_addr = FetchAddr; e_instr = FetchData;
            end
            PLoad:   e_rdy  = ~v.rst;
            PWrite:  e_we   = ~v.rst;
            PFlush:  e_done = ~v.rst;
            PErr:    e_err  = 1'b1;
            default: ;
        endcase
        chk("rx_ready",  idx, 32'(rx_ready),  32'(e_rdy));
        chk("mem_we",    idx, 32'(mem_we),    32'(e_we));
        chk("mem_addr",  idx, 32'(mem_addr),  32'(e_addr));
        chk("cpu_instr", idx, cpu_instr,      e_instr);
        chk("cpu_rst",   idx, 32'(cpu_rst),   32'(e_crst));
        chk("busy",      idx, 32'(busy),      32'(e_busy));
        chk("done",      idx, 32'(done),      32'(e_done));
        chk("err",       idx, 32'(err),       32'(e_err));
        if (e_we) chk("mem_wdata", idx, mem_wdata, v.wdata);
    endtask

    task automatic put(input logic rst, input logic prog, input logic vld, input logic [7:0] d,
                       input logic [2:0] ph, input logic [AW-1:0] a, input logic [31:0] w);
        vecs.push_back(mk(rst, prog, vld, d, ph, a, w));
    endtask

    initial begin
        reset = 1'b1; prog_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_addr = FetchAddr; mem_rdata = FetchData;
        repeat (2) @(posedge clock);

        // Reset state, then plain fetch.
        put(1, 0, 0, 8'h00, PRun, 0, 0);
        put(0, 0, 0, 8'h00, PRun, 0, 0);
        // Two-word load; a byte offered during WRITE must not be taken.
        put(0, 1, 0, 8'h00, PRun, 0, 0);
        put(0, 1, 1, 8'h00, PLoad, 0, 0);
        put(0, 0, 1, 8'h02, PLoad, 0, 0);
        put(0, 0, 1, 8'h3C, PLoad, 0, 0);
        put(0, 0, 1, 8'h01, PLoad, 0, 0);
        put(0, 0, 1, 8'h00, PLoad, 0, 0);
        put(0, 0, 1, 8'h01, PLoad, 0, 0);
        put(0, 0, 1, 8'h00, PWrite, 0, 32'h3C01_0001);
        put(0, 0, 1, 8'h00, PLoad, 1, 0);
        put(0, 0, 1, 8'h00, PLoad, 1, 0);
        put(0, 0, 1, 8'h00, PLoad, 1, 0);
        put(0, 0, 1, 8'h08, PLoad, 1, 0);
        put(0, 0, 0, 8'h00, PWrite, 1, 32'h0000_0008);
`ifdef IMEM_LOADER_CKSUM_EN
        put(0, 0, 1, 8'hBA, PLoad, 2, 0);
`endif
        put(0, 0, 0, 8'h00, PFlush, 2, 0);
        put(0, 0, 0, 8'h00, PRun, 0, 0);
        put(0, 0, 0, 8'h00, PRun, 0, 0);
        // Zero-length image: straight to FLUSH, no write.
        put(0, 1, 0, 8'h00, PRun, 0, 0);
        put(0, 1, 1, 8'h00, PLoad, 2, 0);
        put(0, 0, 1, 8'h00, PLoad, 2, 0);
        put(0, 0, 0, 8'h00, PFlush, 2, 0);
        put(0, 0, 0, 8'h00, PRun, 0, 0);
        // N = 16385 is too large; ERR ignores bytes until a new request edge.
        put(0, 1, 0, 8'h00, PRun, 0, 0);
        put(0, 1, 1, 8'h40, PLoad, 2, 0);
        put(0, 0, 1, 8'h01, PLoad, 2, 0);
        put(0, 0, 1, 8'h55, PErr, 2, 0);
        put(0, 0, 0, 8'h00, PErr, 2, 0);
        put(0, 1, 0, 8'h00, PErr, 2, 0);
        // N = 16384 is the largest legal count; then reset mid-DATA.
        put(0, 1, 1, 8'h40, PLoad, 2, 0);
        put(0, 0, 1, 8'h00, PLoad, 2, 0);
        put(0, 0, 1, 8'h11, PLoad, 0, 0);
        put(0, 0, 1, 8'h22, PLoad, 0, 0);
        put(1, 0, 1, 8'h33, PLoad, 0, 0);
        put(0, 0, 1, 8'h44, PRun, 0, 0);
        put(0, 0, 0, 8'h00, PRun, 0, 0);
        // N = 1 with reset landing on the WRITE cycle: no write strobe.
        put(0, 1, 0, 8'h00, PRun, 0, 0);
        put(0, 1, 1, 8'h00, PLoad, 0, 0);
        put(0, 0, 1, 8'h01, PLoad, 0, 0);
        put(0, 0, 1, 8'hAA, PLoad, 0, 0);
        put(0, 0, 1, 8'hBB, PLoad, 0, 0);
        put(0, 0, 1, 8'hCC, PLoad, 0, 0);
        put(0, 0, 1, 8'hDD, PLoad, 0, 0);
        put(1, 0, 0, 8'h00, PWrite, 0, 32'hAABB_CCDD);
        put(0, 0, 0, 8'h00, PRun, 0, 0);
`ifdef IMEM_LOADER_CKSUM_EN
        // Checksum F6 balances 01+02+03+04; F5 does not.
        for (int pass = 0; pass < 2; pass++) begin
            put(0, 1, 0, 8'h00, PRun, 0, 0);
            put(0, 1, 1, 8'h00, PLoad, 0, 0);
            put(0, 0, 1, 8'h01, PLoad, 0, 0);
            put(0, 0, 1, 8'h01, PLoad, 0, 0);
            put(0, 0, 1, 8'h02, PLoad, 0, 0);
            put(0, 0, 1, 8'h03, PLoad, 0, 0);
            put(0, 0, 1, 8'h04, PLoad, 0, 0);
            put(0, 0, 0, 8'h00, PWrite, 0, 32'h0102_0304);
            put(0, 0, 1, (pass == 0) ? 8'hF6 : 8'hF5, PLoad, 1, 0);
            put(0, 0, 0, 8'h00, (pass == 0) ? PFlush : PErr, 1, 0);
            put(pass[0], 0, 0, 8'h00, (pass == 0) ? PRun : PErr, 1, 0);
            put(0, 0, 0, 8'h00, PRun, 0, 0);
        end
`endif

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Idle timeout after the second data byte of a one-word load.
        @(negedge clock); prog_req = 1'b1; rx_valid = 1'b0;
        @(negedge clock); rx_valid = 1'b1; rx_data = 8'h00;
        @(negedge clock); prog_req = 1'b0; rx_data = 8'h01;
        @(negedge clock); rx_data = 8'h12;
        @(negedge clock); rx_data = 8'h34;
        @(negedge clock); rx_valid = 1'b0;
        repeat (TMO - 1) @(negedge clock);
        #1;
        chk("tmo_err_early", 0, 32'(err), 32'd0);
        chk("tmo_rdy_early", 0, 32'(rx_ready), 32'd1);
        @(negedge clock); #1;
        chk("tmo_err", 0, 32'(err), 32'd1);
        chk("tmo_rdy", 0, 32'(rx_ready), 32'd0);
        chk("tmo_cpu_rst", 0, 32'(cpu_rst), 32'd1);
        // A fresh request edge leaves ERR for HDR0 and clears err.
        @(negedge clock); prog_req = 1'b1;
        @(negedge clock); #1;
        chk("rearm_err", 0, 32'(err), 32'd0);
        chk("rearm_busy", 0, 32'(busy), 32'd1);
        chk("rearm_rdy", 0, 32'(rx_ready), 32'd1);
        @(negedge clock); reset = 1'b1; prog_req = 1'b0;
        @(negedge clock); reset = 1'b0; #1;
        chk("final_busy", 0, 32'(busy), 32'd0);
        chk("final_instr", 0, cpu_instr, FetchData);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
